elevator_ctrl: RTL and testbench

Single-car elevator controller. Accepts a call request on `n` and sequences the car through travel and door-open phases. Drives a red indicator (car moving, do not enter) and a green indicator (doors open, enter). Sits between the call-button synchroniser and the indicator-lamp drivers. All outputs are Moore outputs decoded from registered state.

---
 rtl/elevator_ctrl.sv | 83 ++++++++
 tb/tb_elevator_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/elevator_ctrl.sv
// Single-car elevator controller. It accepts call requests on n and runs the car through
// a MOVE phase (red lamp) and then a DOOR phase (green lamp), queueing one request at most.
module elevator_ctrl #(
  parameter int TRAVEL_CYCLES = 2,
  parameter int DOOR_CYCLES   = 2
) (
  input  logic n,
  output logic r,
  output logic g,
  input  logic clk,
  input  logic reset
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam logic [7:0] TRAVEL_LOAD = 8'(TRAVEL_CYCLES - 1);
  localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    r       = 1'b0;
    g       = 1'b0;
    case (state_q)
      IDLE: begin
        if (n || pend_q) begin
          state_d = MOVE;
          cnt_d   = TRAVEL_LOAD;
          pend_d  = 1'b0;
        end
      end
      MOVE: begin
        r = 1'b1;
        if (n) pend_d = 1'b1;
        if (cnt_q == 8'd0) begin
          state_d = DOOR;
          cnt_d   = DOOR_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DOOR: begin
        g = 1'b1;
        if (cnt_q == 8'd0) begin
          // A request arriving on the expiry edge starts the next trip directly.
          if (n || pend_q) begin
            state_d = MOVE;
            cnt_d   = TRAVEL_LOAD;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (n) pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: a trip-timeline model checked every cycle, plus literal
// expectations for the directed scenarios on the default and a short-travel instance.
module tb_elevator_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic n = 1'b0;
  logic r1, g1, r2, g2;
  int   total = 0;
  int   bad = 0;

  elevator_ctrl #(.TRAVEL_CYCLES(2), .DOOR_CYCLES(2)) dut1 (
    .n(n), .r(r1), .g(g1), .clk(clk), .reset(reset));
  elevator_ctrl #(.TRAVEL_CYCLES(1), .DOOR_CYCLES(3)) dut2 (
    .n(n), .r(r2), .g(g2), .clk(clk), .reset(reset));

  always #5 clk = ~clk;

  // A trip is a timeline of T+D cycles; el counts cycles into the current trip.
  typedef struct packed {
    logic       act;
    logic       q;
    logic [8:0] el;
  } mdl_t;

  mdl_t m1 = '0;
  mdl_t m2 = '0;

  function automatic mdl_t step(input mdl_t s, input logic nn, input int t, input int d);
    mdl_t o;
    o = s;
    if (!s.act) begin
      if (nn) begin
        o.act = 1'b1;
        o.el  = 9'd0;
      end
    end else if (int'(s.el) == t + d - 1) begin
      o.el = 9'd0;
      if (nn || s.q) o.q = 1'b0;
      else o.act = 1'b0;
    end else begin
      o.el = s.el + 9'd1;
      if (nn) o.q = 1'b1;
    end
    return o;
  endfunction

  function automatic logic exp_r(input mdl_t s, input int t);
    return s.act && (int'(s.el) < t);
  endfunction

  function automatic logic exp_g(input mdl_t s, input int t);
    return s.act && (int'(s.el) >= t);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m1 <= '0;
      m2 <= '0;
    end else begin
      m1 <= step(m1, n, 2, 2);
      m2 <= step(m2, n, 1, 3);
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    check("mdl_r1", r1, exp_r(m1, 2));
    check("mdl_g1", g1, exp_g(m1, 2));
    check("mdl_r2", r2, exp_r(m2, 1));
    check("mdl_g2", g2, exp_g(m2, 1));
    check("excl1", r1 & g1, 1'b0);
    check("excl2", r2 & g2, 1'b0);
  end

  task automatic cyc(input logic nv);
    @(negedge clk);
    n = nv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    n = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Bit i of each vector is the value for the i-th cycle of the sequence.
  task automatic seq(input string tag, input int len, input logic [15:0] nv,
                     input logic [15:0] er1, input logic [15:0] eg1,
                     input logic [15:0] er2, input logic [15:0] eg2, input bit chk2);
    for (int i = 0; i < len; i++) begin
      cyc(nv[i]);
      check({tag, "_r1"}, r1, er1[i]);
      check({tag, "_g1"}, g1, eg1[i]);
      check({tag, "_pin1"}, exp_r(m1, 2), er1[i]);
      if (chk2) begin
        check({tag, "_r2"}, r2, er2[i]);
        check({tag, "_g2"}, g2, eg2[i]);
        check({tag, "_pin2"}, exp_g(m2, 1), eg2[i]);
      end
    end
  endtask

  initial begin
    // Reset held with n toggling, then released with n idle.
    for (int i = 0; i < 6; i++) begin
      cyc(logic'($urandom_range(0, 1)));
      check("t1_hold_r1", r1, 1'b0);
      check("t1_hold_g1", g1, 1'b0);
      check("t1_hold_r2", r2, 1'b0);
      check("t1_hold_g2", g2, 1'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    n = 1'b0;
    seq("t1_idle", 5, 16'b0, 16'b0, 16'b0, 16'b0, 16'b0, 1'b1);

    // Single one-cycle request on both parameter sets.
    do_reset();
    seq("t2", 6, 16'b000001, 16'b000011, 16'b001100, 16'b000001, 16'b001110, 1'b1);

    // Alternating pulses, then the trailing trip from the stored request.
    do_reset();
    seq("t3", 14, 16'b00000001010101, 16'b00001100110011, 16'b00110011001100,
        16'b0, 16'b0, 1'b0);

    // Second request during DOOR starts MOVE again without an IDLE cycle.
    do_reset();
    seq("t4", 10, 16'b0000001001, 16'b0000110011, 16'b0011001100, 16'b0, 16'b0, 1'b0);

    // Asynchronous reset mid-trip with a request pending.
    do_reset();
    cyc(1'b1);
    cyc(1'b1);
    check("t5_pre_r1", r1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_async_r1", r1, 1'b0);
    check("t5_async_g1", g1, 1'b0);
    check("t5_async_g2", g2, 1'b0);
    reset = 1'b1;
    seq("t5_after", 4, 16'b0, 16'b0, 16'b0, 16'b0, 16'b0, 1'b1);

    // Randomized traffic with held-request bursts and occasional async reset pulses.
    for (int i = 0; i < 800; i++) begin
      logic nv;
      nv = ($urandom_range(0, 3) == 0);
      if (i >= 300 && i < 320) nv = 1'b1;
      cyc(nv);
      if ($urandom_range(0, 60) == 0) begin
        #2;
        reset = 1'b0;
        #1;
        check("rnd_async_r1", r1, 1'b0);
        check("rnd_async_g2", g2, 1'b0);
        reset = 1'b1;
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
